// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32 load/store unit.
// The access-size encoding matches the decoder's mem_size field.
package rv32_pkg;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_REQ,
      LSU_WAIT,
      LSU_DONE
   } lsu_state_e;

   localparam logic [1:0] MEM_B = 2'd0;
   localparam logic [1:0] MEM_H = 2'd1;
   localparam logic [1:0] MEM_W = 2'd2;

   // Size code 3 is never legal; halves need an even address, words a 4-byte aligned one.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         MEM_B:   bad = 1'b0;
         MEM_H:   bad = addr_lo[0];
         MEM_W:   bad = |addr_lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Byte-lane logic: byte enables and store replication for the outgoing word,
// extraction and sign/zero extension for the returning word.
module rv32_lsu_align
   import rv32_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        sign,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  be,
   output logic [31:0] store_lanes,
   output logic [31:0] load_ext
);

   logic [31:0] shifted;

   // NOTE: every output gets a default before the case, so no path can infer a latch.
   always_comb begin
      shifted     = load_word >> {addr_lo, 3'b000};
      be          = 4'b0000;
      store_lanes = store_data;
      load_ext    = shifted;
      case (size)
         MEM_B: begin
            be          = 4'b0001 << addr_lo;
            store_lanes = {4{store_data[7:0]}};
            load_ext    = {{24{sign & shifted[7]}}, shifted[7:0]};
         end
         MEM_H: begin
            be          = 4'b0011 << {addr_lo[1], 1'b0};
            store_lanes = {2{store_data[15:0]}};
            load_ext    = {{16{sign & shifted[15]}}, shifted[15:0]};
         end
         MEM_W: begin
            be          = 4'b1111;
            store_lanes = store_data;
            load_ext    = shifted;
         end
         default: begin
            be = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/rv32_lsu.sv
// MEM-stage load/store unit: one outstanding access on a req/gnt + rvalid data
// bus, with misalignment rejection and a per-access bus timeout.
module rv32_lsu
   import rv32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [1:0]  mem_size,
   input  logic        mem_sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        lsu_stall,
   output logic [31:0] lsu_rdata,
   output logic        lsu_done,
   output logic        misaligned,
   output logic        bus_err,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_e  state_q, state_d;
   logic [7:0]  tmo_cnt;
   logic [1:0]  size_q;
   logic [1:0]  addr_lo_q;
   logic        sign_q;

   logic        start, start_bad, tmo_last;
   logic        accept, load_hit, timeout;
   logic [3:0]  st_be;
   logic [31:0] st_lanes, ld_ext;
   logic [31:0] store_unused_ext, load_unused_lanes;
   logic [3:0]  load_unused_be;

   assign start     = mem_valid & (memread | memwrite);
   assign start_bad = is_misaligned(mem_size, addr[1:0]);
   assign tmo_last  = (tmo_cnt == TMO_LAST);

   // Store path works on the live decode inputs so the bus fields can be captured at start.
   rv32_lsu_align u_store_align (
      .size        (mem_size),
      .addr_lo     (addr[1:0]),
      .sign        (mem_sign),
      .store_data  (wdata),
      .load_word   (32'h0),
      .be          (st_be),
      .store_lanes (st_lanes),
      .load_ext    (store_unused_ext)
   );

   rv32_lsu_align u_load_align (
      .size        (size_q),
      .addr_lo     (addr_lo_q),
      .sign        (sign_q),
      .store_data  (32'h0),
      .load_word   (dmem_rdata),
      .be          (load_unused_be),
      .store_lanes (load_unused_lanes),
      .load_ext    (ld_ext)
   );

   // NOTE: all clocked state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= LSU_IDLE;
      else     state_q <= state_d;
   end

   // A grant or read response in the last budgeted cycle still completes normally.
   always_comb begin
      state_d    = state_q;
      lsu_stall  = 1'b0;
      lsu_done   = 1'b0;
      misaligned = 1'b0;
      dmem_req   = 1'b0;
      accept     = 1'b0;
      load_hit   = 1'b0;
      timeout    = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (start) begin
               if (start_bad) begin
                  misaligned = 1'b1;
               end else begin
                  accept    = 1'b1;
                  lsu_stall = 1'b1;
                  state_d   = LSU_REQ;
               end
            end
         end
         LSU_REQ: begin
            lsu_stall = 1'b1;
            dmem_req  = 1'b1;
            if (dmem_gnt) begin
               state_d = dmem_we ? LSU_DONE : LSU_WAIT;
            end else if (tmo_last) begin
               timeout = 1'b1;
               state_d = LSU_DONE;
            end
         end
         LSU_WAIT: begin
            lsu_stall = 1'b1;
            if (dmem_rvalid) begin
               load_hit = 1'b1;
               state_d  = LSU_DONE;
            end else if (tmo_last) begin
               timeout = 1'b1;
               state_d = LSU_DONE;
            end
         end
         LSU_DONE: begin
            lsu_done = 1'b1;
            state_d  = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
         size_q     <= MEM_B;
         addr_lo_q  <= '0;
         sign_q     <= 1'b0;
         tmo_cnt    <= '0;
         lsu_rdata  <= '0;
         bus_err    <= 1'b0;
      end else begin
         bus_err <= timeout;
         if (accept) begin
            dmem_we    <= memwrite & ~memread;
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_be    <= st_be;
            dmem_wdata <= st_lanes;
            size_q     <= mem_size;
            addr_lo_q  <= addr[1:0];
            sign_q     <= mem_sign;
            tmo_cnt    <= '0;
         end else if (state_q == LSU_REQ || state_q == LSU_WAIT) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end
         if (load_hit)     lsu_rdata <= ld_ext;
         else if (timeout) lsu_rdata <= '0;
      end
   end

endmodule

// File: tb/tb_rv32_lsu.sv
// Self-checking bench for rv32_lsu: directed scenarios plus randomized
// accesses checked against an arithmetic lane/extension model.
module tb_rv32_lsu;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, memread, memwrite, mem_sign;
   logic [1:0]  mem_size;
   logic [31:0] addr, wdata;
   logic        lsu_stall, lsu_done, misaligned, bus_err;
   logic [31:0] lsu_rdata;
   logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;

   int n_cmp = 0;
   int n_err = 0;
   int stall_cnt = 0;
   int done_cnt = 0;
   logic [31:0] model_rdata = 32'h0;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (lsu_stall === 1'b1) stall_cnt++;
      if (lsu_done === 1'b1) done_cnt++;
   end

   rv32_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_valid   (mem_valid),
      .memread     (memread),
      .memwrite    (memwrite),
      .mem_size    (mem_size),
      .mem_sign    (mem_sign),
      .addr        (addr),
      .wdata       (wdata),
      .lsu_stall   (lsu_stall),
      .lsu_rdata   (lsu_rdata),
      .lsu_done    (lsu_done),
      .misaligned  (misaligned),
      .bus_err     (bus_err),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_be     (dmem_be),
      .dmem_wdata  (dmem_wdata),
      .dmem_gnt    (dmem_gnt),
      .dmem_rvalid (dmem_rvalid),
      .dmem_rdata  (dmem_rdata)
   );

   // ---------------- reference model ----------------
   function automatic logic [3:0] m_be(input int size, input int off);
      logic [3:0] r;
      int nbytes;
      nbytes = 1 << size;
      for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + nbytes);
      return r;
   endfunction

   function automatic logic [31:0] m_lanes(input int size, input logic [31:0] d);
      if (size == 0) return {24'h0, d[7:0]} * 32'h0101_0101;
      if (size == 1) return {16'h0, d[15:0]} * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input int size, input bit sgn, input int off,
                                          input logic [31:0] w);
      longint unsigned v, mask;
      int bits;
      bits = 8 * (1 << size);
      v    = w;
      v    = v >> (8 * off);
      mask = (64'd1 << bits) - 1;
      v    = v & mask;
      if (sgn && v[bits-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   function automatic bit m_mis(input int size, input logic [31:0] a);
      return (size == 3) || ((a % (1 << size)) != 0);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_valid   = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
   endtask

   // One complete access; gd = REQ cycles without grant, rd = WAIT cycles without rvalid.
   task automatic do_access(input bit ld, input bit both, input int size, input bit sgn,
                            input logic [31:0] a, input logic [31:0] wd, input int gd,
                            input int rd, input logic [31:0] word, input string tag);
      logic [31:0] e_addr, e_lanes;
      logic [3:0]  e_be;
      e_addr  = {a[31:2], 2'b00};
      e_be    = m_be(size, int'(a[1:0]));
      e_lanes = m_lanes(size, wd);

      tick();
      mem_valid = 1'b1;
      memread   = ld;
      memwrite  = !ld || both;
      mem_size  = 2'(size);
      mem_sign  = sgn;
      addr      = a;
      wdata     = wd;
      #1;
      n_cmp++; if (lsu_stall !== 1'b1) begin n_err++; $display("FAIL %s start_stall: got %b want 1", tag, lsu_stall); end
      n_cmp++; if (misaligned !== 1'b0 || dmem_req !== 1'b0) begin n_err++; $display("FAIL %s start_flags: mis=%b req=%b want 0/0", tag, misaligned, dmem_req); end

      for (int k = 0; k <= gd; k++) begin
         tick();
         mem_valid   = 1'($urandom);
         memread     = 1'($urandom);
         memwrite    = 1'($urandom);
         mem_size    = 2'($urandom);
         addr        = $urandom;
         wdata       = $urandom;
         dmem_gnt    = (k == gd);
         dmem_rvalid = 1'($urandom);
         dmem_rdata  = $urandom;
         #1;
         n_cmp++; if (dmem_req !== 1'b1 || lsu_stall !== 1'b1) begin n_err++; $display("FAIL %s req_phase: req=%b stall=%b want 1/1", tag, dmem_req, lsu_stall); end
         n_cmp++; if (dmem_addr !== e_addr || dmem_be !== e_be) begin n_err++; $display("FAIL %s bus_addr_be: got %h/%b want %h/%b", tag, dmem_addr, dmem_be, e_addr, e_be); end
         n_cmp++; if (dmem_we !== !ld || (!ld && dmem_wdata !== e_lanes)) begin n_err++; $display("FAIL %s bus_we_wdata: got %b/%h want %b/%h", tag, dmem_we, dmem_wdata, !ld, e_lanes); end
      end
      mem_valid = 1'b0;

      if (ld) begin
         for (int k = 0; k <= rd; k++) begin
            tick();
            dmem_gnt    = 1'($urandom);
            dmem_rvalid = (k == rd);
            dmem_rdata  = (k == rd) ? word : $urandom;
            #1;
            n_cmp++; if (dmem_req !== 1'b0 || lsu_stall !== 1'b1 || lsu_done !== 1'b0) begin n_err++; $display("FAIL %s wait_phase: req=%b stall=%b done=%b want 0/1/0", tag, dmem_req, lsu_stall, lsu_done); end
         end
         model_rdata = m_load(size, sgn, int'(a[1:0]), word);
      end

      // DONE: a new request presented here must be ignored.
      tick();
      dmem_gnt    = 1'($urandom);
      dmem_rvalid = 1'($urandom);
      dmem_rdata  = $urandom;
      mem_valid   = 1'b1;
      memread     = 1'b1;
      mem_size    = 2'($urandom);
      addr        = $urandom;
      #1;
      n_cmp++; if (lsu_done !== 1'b1 || lsu_stall !== 1'b0 || bus_err !== 1'b0 || misaligned !== 1'b0) begin n_err++; $display("FAIL %s done_phase: done=%b stall=%b err=%b mis=%b want 1/0/0/0", tag, lsu_done, lsu_stall, bus_err, misaligned); end
      n_cmp++; if (lsu_rdata !== model_rdata) begin n_err++; $display("FAIL %s rdata: got %h want %h", tag, lsu_rdata, model_rdata); end

      tick();
      idle_inputs();
      #1;
      n_cmp++; if (lsu_done !== 1'b0 || dmem_req !== 1'b0 || lsu_stall !== 1'b0) begin n_err++; $display("FAIL %s after_done: done=%b req=%b stall=%b want 0/0/0", tag, lsu_done, dmem_req, lsu_stall); end
      n_cmp++; if (lsu_rdata !== model_rdata) begin n_err++; $display("FAIL %s rdata_hold: got %h want %h", tag, lsu_rdata, model_rdata); end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      mem_size = 2'd0; mem_sign = 1'b0; addr = '0; wdata = '0; dmem_rdata = '0;
      tick();
      tick();
      n_cmp++; if ({dmem_req, dmem_we, dmem_be, lsu_done, bus_err, lsu_stall, misaligned} !== '0) begin n_err++; $display("FAIL reset_ctrl: got req=%b we=%b be=%b done=%b err=%b stall=%b mis=%b want all 0", dmem_req, dmem_we, dmem_be, lsu_done, bus_err, lsu_stall, misaligned); end
      n_cmp++; if (dmem_addr !== '0 || dmem_wdata !== '0 || lsu_rdata !== '0) begin n_err++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want 0", dmem_addr, dmem_wdata, lsu_rdata); end
      rst = 1'b0;
      model_rdata = 32'h0;
      tick();
   endtask

   task automatic test_lb();
      stall_cnt = 0;
      done_cnt  = 0;
      do_access(1, 0, 0, 1, 32'h0000_1003, 32'h0, 0, 1, 32'h80AB_CDEF, "lb");
      n_cmp++; if (lsu_rdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_value: got %h want ffffff80", lsu_rdata); end
      n_cmp++; if (stall_cnt !== 4) begin n_err++; $display("FAIL lb_stall_cycles: got %0d want 4", stall_cnt); end
      n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL lb_done_pulses: got %0d want 1", done_cnt); end
   endtask

   task automatic test_lhu();
      do_access(1, 0, 1, 0, 32'h0000_2002, 32'h0, 1, 0, 32'hBEEF_1234, "lhu");
      n_cmp++; if (lsu_rdata !== 32'h0000_BEEF) begin n_err++; $display("FAIL lhu_value: got %h want 0000beef", lsu_rdata); end
   endtask

   task automatic test_sb();
      stall_cnt = 0;
      done_cnt  = 0;
      do_access(0, 0, 0, 0, 32'h0000_0011, 32'h0000_00A5, 3, 0, 32'h0, "sb");
      n_cmp++; if (stall_cnt !== 5) begin n_err++; $display("FAIL sb_stall_cycles: got %0d want 5", stall_cnt); end
      n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL sb_done_pulses: got %0d want 1", done_cnt); end
   endtask

   task automatic test_misaligned();
      int          sz;
      logic [31:0] a;
      for (int i = 0; i < 12; i++) begin
         if (i == 0) begin sz = 2; a = 32'h6; end
         else if (i == 1) begin sz = 1; a = 32'h101; end
         else if (i == 2) begin sz = 3; a = 32'h0; end
         else begin
            sz = $urandom_range(1, 3);
            a  = $urandom;
            while (!m_mis(sz, a)) a = $urandom;
         end
         tick();
         mem_valid = 1'b1;
         memread   = (i % 3) != 1;
         memwrite  = (i % 3) != 0;
         mem_size  = 2'(sz);
         addr      = a;
         #1;
         n_cmp++; if (misaligned !== 1'b1 || lsu_stall !== 1'b0 || dmem_req !== 1'b0) begin n_err++; $display("FAIL mis_%0d start: mis=%b stall=%b req=%b want 1/0/0", i, misaligned, lsu_stall, dmem_req); end
         tick();
         idle_inputs();
         #1;
         n_cmp++; if (misaligned !== 1'b0 || dmem_req !== 1'b0 || lsu_done !== 1'b0) begin n_err++; $display("FAIL mis_%0d after: mis=%b req=%b done=%b want 0/0/0", i, misaligned, dmem_req, lsu_done); end
      end
   endtask

   task automatic test_ignore_idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         dmem_gnt    = 1'b1;
         dmem_rvalid = 1'b1;
         dmem_rdata  = $urandom;
         #1;
         n_cmp++; if (dmem_req !== 1'b0 || lsu_done !== 1'b0 || lsu_rdata !== model_rdata) begin n_err++; $display("FAIL idle_ignore: req=%b done=%b rdata=%h want 0/0/%h", dmem_req, lsu_done, lsu_rdata, model_rdata); end
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_timeout(input bit grant_first, input string tag);
      int  cyc;
      bit  seen;
      tick();
      mem_valid = 1'b1;
      memread   = 1'b1;
      memwrite  = 1'b0;
      mem_size  = 2'd2;
      addr      = 32'h0000_0100;
      #1;
      cyc  = 0;
      seen = 0;
      for (int k = 0; k < TMO + 4 && !seen; k++) begin
         tick();
         mem_valid   = 1'b0;
         dmem_gnt    = grant_first && (k == 0);
         dmem_rvalid = 1'b0;
         #1;
         if (lsu_done === 1'b1) seen = 1;
         else cyc++;
      end
      if (!seen) begin
         n_cmp++; n_err++;
         $display("FAIL %s no_done: got no lsu_done within %0d cycles want done", tag, TMO + 4);
      end else begin
         model_rdata = 32'h0;
         n_cmp++; if (cyc !== TMO) begin n_err++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, cyc, TMO); end
         n_cmp++; if (bus_err !== 1'b1 || dmem_req !== 1'b0 || lsu_stall !== 1'b0) begin n_err++; $display("FAIL %s abort_flags: err=%b req=%b stall=%b want 1/0/0", tag, bus_err, dmem_req, lsu_stall); end
         n_cmp++; if (lsu_rdata !== 32'h0) begin n_err++; $display("FAIL %s abort_rdata: got %h want 0", tag, lsu_rdata); end
      end
      tick();
      idle_inputs();
      #1;
      n_cmp++; if (bus_err !== 1'b0 || lsu_done !== 1'b0) begin n_err++; $display("FAIL %s pulse_width: err=%b done=%b want 0/0", tag, bus_err, lsu_done); end
   endtask

   task automatic test_reset_mid();
      // Reset while waiting for grant.
      tick();
      mem_valid = 1'b1; memread = 1'b0; memwrite = 1'b1; mem_size = 2'd2; addr = 32'h40; wdata = $urandom;
      tick();
      mem_valid = 1'b0;
      #1;
      n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rst_req pre: got req=%b want 1", dmem_req); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (dmem_req !== 1'b0 || lsu_stall !== 1'b0) begin n_err++; $display("FAIL rst_req post: req=%b stall=%b want 0/0", dmem_req, lsu_stall); end

      // Reset while waiting for data, then a stray response.
      do_access(1, 0, 2, 0, 32'h0000_0080, 32'h0, 0, 0, 32'h1357_9BDF, "rst_pre_load");
      tick();
      mem_valid = 1'b1; memread = 1'b1; memwrite = 1'b0; mem_size = 2'd2; addr = 32'h84;
      tick();
      mem_valid = 1'b0;
      dmem_gnt  = 1'b1;
      tick();
      dmem_gnt  = 1'b0;
      rst       = 1'b1;
      tick();
      rst         = 1'b0;
      model_rdata = 32'h0;
      for (int i = 0; i < 2; i++) begin
         dmem_rvalid = 1'b1;
         dmem_rdata  = 32'hDEAD_BEEF;
         #1;
         n_cmp++; if (dmem_req !== 1'b0 || lsu_stall !== 1'b0 || lsu_done !== 1'b0 || lsu_rdata !== model_rdata) begin n_err++; $display("FAIL rst_wait stray_%0d: req=%b stall=%b done=%b rdata=%h want 0/0/0/%h", i, dmem_req, lsu_stall, lsu_done, lsu_rdata, model_rdata); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_random();
      int          sz;
      bit          ld, both;
      logic [31:0] a;
      for (int i = 0; i < 40; i++) begin
         sz   = $urandom_range(0, 2);
         ld   = 1'($urandom);
         both = ld && ($urandom_range(0, 3) == 0);
         a    = $urandom & ~(32'((1 << sz) - 1));
         do_access(ld, both, sz, 1'($urandom), a, $urandom, $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom, "rand");
      end
   endtask

   initial begin
      test_reset();
      test_lb();
      test_lhu();
      test_sb();
      test_misaligned();
      test_ignore_idle();
      test_timeout(1'b1, "tmo_wait");
      test_timeout(1'b0, "tmo_req");
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/rv32_lsu.md
RV32_LSU -- requirements
Module: rv32_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 64, max cycles spent in REQ+WAIT before the access is aborted (range 2..255).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- mem_valid  in  1  MEM-stage instruction valid
- memread  in  1  decoded load
- memwrite  in  1  decoded store
- mem_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- mem_sign  in  1  1=sign-extend load
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- lsu_stall  out  1  hold IF..MEM
- lsu_rdata  out  32  extended load result
- lsu_done  out  1  access-complete pulse
- misaligned  out  1  misaligned/illegal-size pulse
- bus_err  out  1  timeout pulse
- dmem_req  out  1  bus request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data word

Function
REQ-003 The FSM SHALL have states LSU_IDLE, LSU_REQ, LSU_WAIT and LSU_DONE.
REQ-004 A start condition SHALL be mem_valid & (memread | memwrite) while in IDLE; when memread and memwrite are both set, the access SHALL be treated as a load.
REQ-005 A start SHALL be misaligned when size=half with addr[0]=1, size=word with addr[1:0]!=0, or size=3.
REQ-006 On a misaligned start, the block SHALL assert misaligned combinationally that cycle, SHALL NOT stall, SHALL make no bus access, and SHALL stay in IDLE.
REQ-007 On a legal start, the block SHALL:
- register we, addr, size, sign, be and wdata;
- move to REQ;
- assert lsu_stall combinationally in that cycle.
REQ-008 In REQ, dmem_req=1 and all dmem_* outputs SHALL remain stable until the cycle dmem_gnt=1; then a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-009 In WAIT, on dmem_rvalid=1 the block SHALL register the extended data into lsu_rdata and go to DONE.
REQ-010 dmem_gnt outside REQ and dmem_rvalid outside WAIT SHALL be ignored.
REQ-011 In DONE, the block SHALL:
- assert lsu_done=1 and lsu_stall=0;
- ignore mem_valid;
- return to IDLE next cycle.
REQ-012 lsu_stall SHALL equal (IDLE & legal start) | REQ | WAIT.
REQ-013 Byte enables SHALL be:
- byte: 4'b0001<<addr[1:0]
- half: 4'b0011<<{addr[1],1'b0}
- word: 4'b1111
REQ-014 Store data SHALL be replicated by size: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-015 Load data SHALL be dmem_rdata>>(8*addr[1:0]), truncated to the size, then sign- or zero-extended per mem_sign.
REQ-016 A timeout counter SHALL clear on entry to REQ and increment each cycle in REQ/WAIT. On reaching TIMEOUT_CYCLES it SHALL:
- pulse bus_err;
- drop dmem_req;
- set lsu_rdata=0;
- go to DONE.
REQ-017 lsu_rdata SHALL hold its value until the next load completes.

Reset
REQ-018 While rst=1 at a clock edge, the block SHALL reset as follows:
- state SHALL become IDLE;
- dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, lsu_rdata, lsu_done, bus_err and the timeout counter SHALL become 0.
REQ-019 A reset asserted in REQ or WAIT SHALL deassert dmem_req from the following cycle, and a later dmem_rvalid SHALL be ignored.

Structure
REQ-020 rv32_pkg SHALL hold the lsu_state_e enum and the constants MEM_B=2'd0, MEM_H=2'd1 and MEM_W=2'd2.
REQ-021 The lane logic (be, store replication, load extract/extend) SHALL be one combinational sub-module, rv32_lsu_align, instantiated once for the store path and once for the load path.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- LB: addr=0x1003, sign=1, gnt at cycle 1, rvalid at cycle 3 with 0x80xxxxxx -> be=4'b1000, lsu_rdata=0xFFFFFF80, stall for 4 cycles, one lsu_done pulse.
- LHU: addr=0x2002, rdata=0xBEEF1234 -> be=4'b1100, lsu_rdata=0x0000BEEF.
- SB: addr=0x11, wdata=0x000000A5, gnt held low for 3 cycles -> req/addr=0x10/be=4'b0010/wdata=0xA5A5A5A5 stable throughout, done the cycle after gnt.
- LW at addr=0x6 -> misaligned=1 same cycle, lsu_stall=0, dmem_req never asserted.
- Load with no rvalid, TIMEOUT_CYCLES=8 -> bus_err and lsu_done pulse, lsu_rdata=0; rst in WAIT followed by a stray rvalid -> IDLE, lsu_rdata unchanged at 0.
